// File: rtl/plus_kbd_responder.sv
// Mac Plus keyboard protocol engine: buffers MCU key events and answers
// Instant/Inquiry/Model/Test commands from the VIA shifter with reply bytes.
module plus_kbd_responder #(
    parameter int          FIFO_AW     = 3,
    parameter int          INQ_TIMEOUT = 2000000,
    parameter logic [7:0]  MODEL_ID    = 8'h0B
) (
    input  logic        clk,
    input  logic        _reset,
    input  logic        en,
    input  logic        kbd_strobe,
    input  logic [9:0]  kbd_data,
    input  logic [7:0]  data_out,
    input  logic        strobe_out,
    output logic [7:0]  data_in,
    output logic        strobe_in,
    output logic        kbd_overflow
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CNT_W = FIFO_AW + 1;
    localparam int TMO_W = $clog2(INQ_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(INQ_TIMEOUT - 1);

    localparam logic [7:0] CMD_INQUIRY = 8'h10;
    localparam logic [7:0] CMD_INSTANT = 8'h14;
    localparam logic [7:0] CMD_MODEL   = 8'h16;
    localparam logic [7:0] CMD_TEST    = 8'h36;
    localparam logic [7:0] RPL_NULL    = 8'h7B;
    localparam logic [7:0] RPL_KEYPAD  = 8'h79;
    localparam logic [7:0] RPL_TEST    = 8'h7D;

    typedef enum logic [1:0] {S_IDLE, S_INQ_WAIT, S_REPLY} state_t;

    state_t               r_state, w_state_next;
    logic [8:0]           r_fifo [0:DEPTH-1];
    logic [FIFO_AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_prefix, w_prefix_next;
    logic                 r_overflow;
    logic [TMO_W-1:0]     r_cnt, w_cnt_next;
    logic                 r_strobe_last, r_armed;
    logic [7:0]           r_data_in;
    logic                 r_strobe_in;
    logic                 r_pend_valid, w_pend_valid_next;
    logic [7:0]           r_pend_cmd, w_pend_cmd_next;

    logic                 w_event, w_full, w_empty, w_push, w_pop, w_flush;
    logic [8:0]           w_head;
    logic                 w_head_is_prefix;
    logic [7:0]           w_head_byte;
    logic                 w_cmd_valid;
    logic [7:0]           w_cmd;
    logic                 w_reply_valid;
    logic [7:0]           w_reply_byte;

    assign w_event = r_armed && (kbd_strobe != r_strobe_last);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = w_event && !w_full && !w_flush;

    // Stored entry layout: {keypad, release, code[6:0]}
    assign w_head           = r_fifo[r_rd_ptr];
    assign w_head_is_prefix = w_head[8] && !r_prefix;
    assign w_head_byte      = w_head_is_prefix ? RPL_KEYPAD : {w_head[7], w_head[6:1], 1'b1};

    // A command caught during REPLY is replayed from IDLE one tick later
    assign w_cmd_valid = strobe_out || r_pend_valid;
    assign w_cmd       = strobe_out ? data_out : r_pend_cmd;

    always_comb begin
        w_state_next      = r_state;
        w_prefix_next     = r_prefix;
        w_cnt_next        = r_cnt;
        w_pend_valid_next = r_pend_valid;
        w_pend_cmd_next   = r_pend_cmd;
        w_reply_valid     = 1'b0;
        w_reply_byte      = r_data_in;
        w_pop             = 1'b0;
        w_flush           = 1'b0;

        if (r_state == S_REPLY) begin
            w_state_next = S_IDLE;
            if (strobe_out) begin
                w_pend_valid_next = 1'b1;
                w_pend_cmd_next   = data_out;
            end
        end else if (w_cmd_valid) begin
            w_pend_valid_next = 1'b0;
            w_state_next      = S_IDLE;
            case (w_cmd)
                CMD_INSTANT, CMD_INQUIRY: begin
                    if (!w_empty) begin
                        w_reply_valid = 1'b1;
                        w_reply_byte  = w_head_byte;
                        w_pop         = !w_head_is_prefix;
                        w_prefix_next = w_head_is_prefix;
                    end else if (w_cmd == CMD_INSTANT) begin
                        w_reply_valid = 1'b1;
                        w_reply_byte  = RPL_NULL;
                    end else begin
                        w_state_next = S_INQ_WAIT;
                        w_cnt_next   = '0;
                    end
                end
                CMD_MODEL: begin
                    w_reply_valid = 1'b1;
                    w_reply_byte  = MODEL_ID;
                    w_flush       = 1'b1;
                    w_prefix_next = 1'b0;
                end
                CMD_TEST: begin
                    w_reply_valid = 1'b1;
                    w_reply_byte  = RPL_TEST;
                end
                default: ;
            endcase
        end else if (r_state == S_INQ_WAIT) begin
            w_cnt_next = r_cnt + 1'b1;
            if (!w_empty) begin
                w_reply_valid = 1'b1;
                w_reply_byte  = w_head_byte;
                w_pop         = !w_head_is_prefix;
                w_prefix_next = w_head_is_prefix;
            end else if (r_cnt == TMO_LAST) begin
                w_reply_valid = 1'b1;
                w_reply_byte  = RPL_NULL;
            end
        end

        if (w_reply_valid) begin
            w_state_next = S_REPLY;
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_state      <= S_IDLE;
            r_prefix     <= 1'b0;
            r_cnt        <= '0;
            r_pend_valid <= 1'b0;
            r_pend_cmd   <= 8'h00;
            r_data_in    <= 8'h00;
            r_strobe_in  <= 1'b0;
        end else if (en) begin
            r_state      <= w_state_next;
            r_prefix     <= w_prefix_next;
            r_cnt        <= w_cnt_next;
            r_pend_valid <= w_pend_valid_next;
            r_pend_cmd   <= w_pend_cmd_next;
            r_strobe_in  <= w_reply_valid;
            if (w_reply_valid) begin
                r_data_in <= w_reply_byte;
            end
        end
    end

    // First clock after reset only samples the strobe level, so no event is taken
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_armed       <= 1'b0;
            r_strobe_last <= 1'b0;
        end else if (!r_armed) begin
            r_armed       <= 1'b1;
            r_strobe_last <= kbd_strobe;
        end else if (en) begin
            r_strobe_last <= kbd_strobe;
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (en) begin
            if (w_flush) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
                if (w_event && w_full) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en && w_push) begin
            r_fifo[r_wr_ptr] <= {kbd_data[9], kbd_data[8], kbd_data[6:0]};
        end
    end

    assign data_in      = r_data_in;
    assign strobe_in    = r_strobe_in;
    assign kbd_overflow = r_overflow;

endmodule
